tick_gen: RTL
=============

# tick_gen

Parametrised multi-channel tick generator; successor to the fixed single-rate divider. Each of CH independent channels divides `clk_in` by a runtime-programmable divisor. It emits either a one-cycle tick (pulse mode) or a 50 % square wave (square mode). Divisor and mode are loaded through a valid/ready config port and take effect glitch-free at the channel's next terminal count. Sits between the board clock and the timing consumers: display scan, debounce and the 1 Hz seconds counter.

## Interface
- `CH`, 4, number of channels (1..16)
- `CW`, 16, divisor/counter width
- `DEF_DIV`, 500, divisor loaded on reset into every channel (must fit CW, ≥1)

- `clk_in`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  CH  per-channel count enable
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write accepted when `cfg_valid && cfg_ready`
- `cfg_ch`  in  max(1,$clog2(CH))  target channel
- `cfg_div`  in  CW  new divisor
- `cfg_mode`  in  1  0 = pulse, 1 = square
- `tick_out`  out  CH  registered one-cycle tick per channel
- `sq_out`  out  CH  registered square output per channel

## Operation
- Per channel: `cnt` (CW), active `div`/`mode`, shadow `sdiv`/`smode`, `pend` flag.
- Enabled: `cnt` counts 0..div-1. Terminal count (TC) = `en && cnt == div-1`. At TC, `cnt` returns to 0.
- Pulse mode: `tick_out` is high for exactly the one cycle after each TC, so the period is `div` cycles. `sq_out` is held 0.
- Square mode: `sq_out` toggles on each TC, so the period is 2·div. `tick_out` still pulses on each TC.
- `div` of 0 or 1 is treated as 1: TC occurs every enabled cycle, so `tick_out` stays high continuously and `sq_out` toggles every cycle.
- `en` low: `cnt`, `sq_out` and `div` hold; `tick_out` is 0 in the following cycle.
- Config: `cfg_ready = !rst && !pend[cfg_ch]`.
  - On accept, the write goes to `sdiv`/`smode` and sets `pend`.
  - If `cfg_ch >= CH`, the write is accepted and dropped.
- Pending apply:
  - An enabled channel copies shadow to active at its next TC, clears `pend`, and restarts from `cnt=0`.
  - A disabled channel applies in the cycle after accept and clears `cnt` to 0.
  - On a mode change, `sq_out` is cleared at the apply.
- Same-cycle accept and TC on the target channel: the TC uses the old settings; the new settings apply at the following TC.
- Counter arithmetic is unsigned CW-bit. `cnt` never exceeds `div-1` because it restarts on apply.

## Timing
- Reset values:
  - `cnt=0`, `div=DEF_DIV`, mode = pulse, `pend=0`
  - `tick_out=0`, `sq_out=0`
  - `cfg_ready=0` during `rst`, 1 in the first cycle after
- Taking the first cycle after reset release with `en=1` as cycle 0, `cnt==k` in cycle k. The first `tick_out` is in cycle `div`, then every `div` cycles.
- Config latency:
  - Accept is in cycle a. The new period starts counting from the cycle after the next TC.
  - `cfg_ready` for that channel is low from a+1 until the cycle after the apply.
- `rst` mid-count or with `pend` set discards the count and any pending write. All channels restart at `DEF_DIV`.
- Channels are fully independent; simultaneous TCs on several channels are allowed.

## Structure
- Shared package `tick_pkg`: mode encoding constants `MODE_PULSE=1'b0`, `MODE_SQ=1'b1`, and a `DEF_DIV` default constant.
- One sub-module, `tick_chan`, holds one channel's counter, shadow registers and output registers. `tick_gen` instantiates CH copies in a generate loop and decodes `cfg_ch` into per-channel write strobes and the `cfg_ready` mux.

## Test plan
- Reset, `en=4'b1111`, no config: every channel's `tick_out` first high in cycle 500, period 500, width 1. `sq_out=0`.
- Write ch1 `div=10`, `mode=square` while counting: `cfg_ready` drops for ch1 until the next TC. After apply, `sq_out[1]` is 10 high / 10 low. Ch0 and ch2–3 are unaffected.
- Write ch2 `div=1`: `tick_out[2]` stays continuously high while `en[2]=1`. Writing `div=0` gives the same.
- Write ch0 in the exact cycle of its TC: the next period is still the old value (500), and the period after that is the new value.
- `en[3]` low for 7 cycles at `cnt=200`: count holds, no tick. It resumes at 201 and the tick is delayed by 7 cycles. A write to disabled ch3 applies the next cycle with `cnt=0`.
- `rst` pulsed with `pend[1]` set: the pending write is lost, all divisors return to 500, and outputs are 0 in the cycle after `rst`.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared constants for the multi-channel tick generator: mode encodings,
// the reset divisor and the channel-select width helper.
package tick_pkg;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_SQ    = 1'b1;

  localparam int DEF_DIV = 500;

  // A single-channel build still needs a one-bit select so the port exists.
  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Configuration write port of tick_gen: valid/ready handshake carrying the
// target channel, new divisor and output mode.
interface tick_gen_if #(
  parameter int CH = 4,
  parameter int CW = 16
);
  import tick_pkg::*;

  localparam int CHW = ch_width(CH);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/tick_chan.sv
// One tick channel: divide counter, active and shadow divisor/mode, and the
// registered tick and square outputs. Shadow settings go live at a safe point.
module tick_chan
  import tick_pkg::*;
#(
  parameter int CW      = 16,
  parameter int RST_DIV = 500
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_wr,
  input  logic [CW-1:0] i_div,
  input  logic          i_mode,
  output logic          o_pend,
  output logic          o_tick,
  output logic          o_sq
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [CW-1:0] r_sdiv;
  logic          r_mode;
  logic          r_smode;
  logic          r_pend;
  logic          r_tick;
  logic          r_sq;

  logic [CW-1:0] w_last;
  logic          w_tc;
  logic          w_apply;
  logic          w_mode_chg;

  // Divisors of 0 and 1 both collapse to a terminal count on every enabled cycle.
  assign w_last     = (r_div > CW'(1)) ? (r_div - CW'(1)) : '0;
  assign w_tc       = i_en && (r_cnt == w_last);
  assign w_apply    = r_pend && (w_tc || !i_en);
  assign w_mode_chg = (r_smode != r_mode);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt   <= '0;
      r_div   <= CW'(RST_DIV);
      r_sdiv  <= CW'(RST_DIV);
      r_mode  <= MODE_PULSE;
      r_smode <= MODE_PULSE;
      r_pend  <= 1'b0;
      r_tick  <= 1'b0;
      r_sq    <= 1'b0;
    end else begin
      r_tick <= w_tc;

      if (i_wr) begin
        r_sdiv  <= i_div;
        r_smode <= i_mode;
        r_pend  <= 1'b1;
      end

      // The terminal count that performs an apply still toggles under the old mode.
      if (w_apply) begin
        r_div  <= r_sdiv;
        r_mode <= r_smode;
        r_pend <= 1'b0;
        r_cnt  <= '0;
        if (w_mode_chg) begin
          r_sq <= 1'b0;
        end else if (w_tc && (r_mode == MODE_SQ)) begin
          r_sq <= ~r_sq;
        end
      end else if (w_tc) begin
        r_cnt <= '0;
        if (r_mode == MODE_SQ) begin
          r_sq <= ~r_sq;
        end
      end else if (i_en) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pend = r_pend;
  assign o_tick = r_tick;
  assign o_sq   = r_sq;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: CH independent dividers of
// clk_in, each reprogrammable through a shared valid/ready config port.
module tick_gen #(
  parameter int CH      = 4,
  parameter int CW      = 16,
  parameter int DEF_DIV = tick_pkg::DEF_DIV
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic [CH-1:0] en,
  tick_gen_if.slave     cfg,
  output logic [CH-1:0] tick_out,
  output logic [CH-1:0] sq_out
);
  import tick_pkg::*;

  localparam int CHW = ch_width(CH);

  logic [CH-1:0] w_pend;
  logic [CH-1:0] w_wr;
  logic          w_pend_sel;
  logic          w_accept;

  // A select beyond the last channel matches nothing, so it is accepted and dropped.
  always_comb begin
    w_pend_sel = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) begin
        w_pend_sel = w_pend[i];
      end
    end
  end

  assign cfg.cfg_ready = !rst && !w_pend_sel;
  assign w_accept      = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < CH; i++) begin
      w_wr[i] = w_accept && (cfg.cfg_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    tick_chan #(
      .CW      (CW),
      .RST_DIV (DEF_DIV)
    ) u_chan (
      .clk_in (clk_in),
      .rst    (rst),
      .i_en   (en[g]),
      .i_wr   (w_wr[g]),
      .i_div  (cfg.cfg_div),
      .i_mode (cfg.cfg_mode),
      .o_pend (w_pend[g]),
      .o_tick (tick_out[g]),
      .o_sq   (sq_out[g])
    );
  end

endmodule
